dvi_timing_sched: RTL
=====================

DVI_TIMING_SCHED -- requirements
Module: dvi_timing_sched

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch (H_TOTAL = sum of the four = 800).
REQ-005 SHALL have parameter V_ACTIVE, 480, active lines per frame.
REQ-006 SHALL have parameter V_FP, 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, 33, vertical back porch (V_TOTAL = 525).
REQ-009 SHALL have a single clock domain and an asynchronous, active-high reset, with ports: pix_clk input 1 pixel clock; rst input 1 reset.
REQ-010 en  input  1  run request, sampled at frame boundary.
REQ-011 src_valid  input  1  pixel source has a pixel.
REQ-012 src_data  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-013 src_ready  output  1  scheduler accepts a pixel this cycle.
REQ-014 x, y  output  13 each  position of the current output pixel.
REQ-015 de, hsync, vsync  output  1 each  DrawArea / hSync / vSync to the TMDS encoders.
REQ-016 r, g, b  output  8 each  pixel data to the TMDS encoders.
REQ-017 frame_start  output  1  one-cycle pulse at output position (0,0).
REQ-018 underflow  output  1  sticky flag: an active pixel found the FIFO empty.

Function
REQ-019 SHALL contain a 4-entry, 24-bit pixel FIFO; push when src_valid && src_ready; src_ready = !full, so a full FIFO does not push even in a cycle that pops.
REQ-020 SHALL have states IDLE and RUN; IDLE->RUN on the first cycle en=1; RUN->IDLE only at the last pixel of the frame (hc=H_TOTAL-1, vc=V_TOTAL-1) when en=0 on that cycle; en changes mid-frame have no effect.
REQ-021 In RUN: internal hc SHALL increment modulo H_TOTAL; vc SHALL increment modulo V_TOTAL when hc wraps.
REQ-022 In IDLE: hc=vc=0 held; de, hsync, vsync, frame_start, r, g and b all 0; FIFO still accepts pushes.
REQ-023 Active region (internal) SHALL be hc<H_ACTIVE && vc<V_ACTIVE.
REQ-024 hsync SHALL be active-high for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751); vsync SHALL be active-high for 490 <= vc < 492.
REQ-025 The FIFO SHALL pop in the same cycle as an active internal position when it is non-empty; it SHALL NOT pop outside the active region.
REQ-026 All outputs SHALL be registered with exactly 1 cycle latency from the internal position and mutually aligned (x, y, de, syncs, rgb, frame_start).
REQ-027 rgb SHALL be 0 whenever de=0.
REQ-028 An active position with an empty FIFO SHALL set underflow; rgb then follows REQ-033.
REQ-029 underflow SHALL clear on the cycle frame_start is asserted, unless an underflow occurs in that same cycle (set wins).
REQ-030 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged; a simultaneous push and pop on an empty FIFO SHALL NOT bypass (the output is an underflow).

Reset
REQ-031 On rst: state=IDLE, hc=vc=0, FIFO emptied, all outputs 0; after reset release src_ready=1.
REQ-032 rst asserted mid-frame SHALL abort the frame immediately; the frame restarts at (0,0) on the first RUN cycle after reset release.

Configuration
REQ-033 Macro VIDEO_TEST_PATTERN_EN, when defined: an underflowed active pixel SHALL output a color bar (bar = x/80: white, yellow, cyan, green, magenta, red, blue, black, using 8'hFF/8'h00 components). When undefined: an underflowed active pixel SHALL output r=g=b=0. Underflow flagging SHALL be identical in both builds.

Verification
REQ-034 Reset, en=1, src_valid=1 with an incrementing pattern -> first output cycle x=0, y=0, de=1, frame_start=1, rgb=first pushed pixel; a full frame has 307200 de cycles and 420000 cycles total.
REQ-035 Run a full frame -> hsync high exactly 96 cycles per line, starting at x=656; vsync high for lines 490-491 only.
REQ-036 src_valid=0 during line 10 -> underflow=1 from the first active pixel of line 10; rgb=0 (macro off) or bar colors, e.g. x=100 gives yellow FF/FF/00 (macro on); underflow clears at the next frame_start.
REQ-037 en dropped at y=200 -> frame completes to (799,524), then IDLE with outputs 0; en raised again -> restart at (0,0) with frame_start.
REQ-038 src_valid=1 held with the FIFO full during blanking -> src_ready=0, no data loss; the first active pixel of the next line equals the oldest queued entry.
REQ-039 rst pulsed at x=300, y=100 -> all outputs 0 asynchronously, FIFO empty; resumes at (0,0).

Source files
------------

// File: rtl/dvi_timing_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : dvi_timing_sched_if
// Description : Pixel-source handshake between a pixel producer and the
//               DVI timing scheduler. A pixel transfers on every cycle where
//               src_valid && src_ready.
// Signals     : src_valid  producer has a pixel
//               src_data   24-bit pixel {R[23:16], G[15:8], B[7:0]}
//               src_ready  scheduler accepts a pixel this cycle
// Modports    : master (pixel producer), slave (scheduler)
// Revision    : 1.0 - initial release
// ============================================================================
interface dvi_timing_sched_if;
  logic        src_valid;
  logic [23:0] src_data;
  logic        src_ready;

  modport master (output src_valid, output src_data, input src_ready);
  modport slave  (input src_valid, input src_data, output src_ready);
endinterface
`default_nettype wire

// File: rtl/dvi_timing_sched.sv
`default_nettype none
// ============================================================================
// Module      : dvi_timing_sched
// Description : DVI/VGA raster timing generator with a 4-entry pixel FIFO.
//               Walks an internal (hc, vc) position while running, pops one
//               pixel per active position and presents position, syncs, DE
//               and RGB to the TMDS encoders one cycle later. Run/stop
//               requests take effect only at frame boundaries.
// Ports       : pix_clk      pixel clock
//               rst          asynchronous active-high reset
//               en           run request, acted on at frame boundary
//               src          pixel source handshake (slave modport)
//               x, y         output pixel position (13 bits each)
//               de           draw-area enable
//               hsync, vsync active-high sync pulses
//               r, g, b      pixel components
//               frame_start  one-cycle pulse at output position (0,0)
//               underflow    sticky: an active pixel found the FIFO empty,
//                            cleared at the next frame_start
// Macro       : VIDEO_TEST_PATTERN_EN - underflowed active pixels show an
//               8-bar colour pattern instead of black.
// Revision    : 1.0 - initial release
// ============================================================================
module dvi_timing_sched #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                pix_clk,
  input  logic                rst,
  input  logic                en,
  dvi_timing_sched_if.slave   src,
  output logic [12:0]         x,
  output logic [12:0]         y,
  output logic                de,
  output logic                hsync,
  output logic                vsync,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b,
  output logic                frame_start,
  output logic                underflow
);

  localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [12:0] H_ACT_C  = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT_C  = 13'(V_ACTIVE);
  localparam logic [12:0] H_LAST_C = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST_C = 13'(V_TOTAL - 1);
  localparam logic [12:0] HS_BEG_C = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END_C = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG_C = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END_C = 13'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VIDEO_TEST_PATTERN_EN
  // Eight equal-width bars across the active line; never divide by zero.
  localparam logic [12:0] BAR_W_C  = 13'((H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1);
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] hc_q, hc_d;
  logic [12:0] vc_q, vc_d;

  logic [23:0] mem_q [4];
  logic [23:0] mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;

  logic [12:0] x_q, x_d;
  logic [12:0] y_q, y_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [23:0] rgb_q, rgb_d;
  logic        frame_start_q, frame_start_d;
  logic        underflow_q, underflow_d;

  logic        run;
  logic        active;
  logic        empty;
  logic        full;
  logic        ready;
  logic        push;
  logic        pop;
  logic        last_pixel;
`ifdef VIDEO_TEST_PATTERN_EN
  logic [12:0] bar;
`endif

  always_comb begin
    run        = (state_q == ST_RUN);
    active     = run && (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
    empty      = (count_q == 3'd0);
    full       = (count_q == 3'd4);
    // Held low while in reset so every output reads 0 during rst.
    ready      = !full && !rst;
    push       = src.src_valid && ready;
    // Occupancy before this cycle's push decides the pop, so an empty FIFO
    // never forwards a same-cycle push straight to the output.
    pop        = active && !empty;
    last_pixel = (hc_q == H_LAST_C) && (vc_q == V_LAST_C);
`ifdef VIDEO_TEST_PATTERN_EN
    bar        = hc_q / BAR_W_C;
`endif
  end

  assign src.src_ready = ready;

  // Raster walk and run/stop control.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    case (state_q)
      ST_IDLE: begin
        hc_d = 13'd0;
        vc_d = 13'd0;
        if (en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_pixel) begin
          hc_d = 13'd0;
          vc_d = 13'd0;
          if (!en) begin
            state_d = ST_IDLE;
          end
        end else if (hc_q == H_LAST_C) begin
          hc_d = 13'd0;
          vc_d = vc_q + 13'd1;
        end else begin
          hc_d = hc_q + 13'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hc_d    = 13'd0;
        vc_d    = 13'd0;
      end
    endcase
  end

  // Pixel FIFO.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = src.src_data;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Output stage: everything is registered from the same internal position
  // so all outputs stay mutually aligned.
  always_comb begin
    x_d           = hc_q;
    y_d           = vc_q;
    de_d          = active;
    hsync_d       = run && (hc_q >= HS_BEG_C) && (hc_q < HS_END_C);
    vsync_d       = run && (vc_q >= VS_BEG_C) && (vc_q < VS_END_C);
    frame_start_d = run && (hc_q == 13'd0) && (vc_q == 13'd0);
    rgb_d         = 24'h000000;
    if (active) begin
      if (!empty) begin
        rgb_d = mem_q[rd_ptr_q];
      end else begin
`ifdef VIDEO_TEST_PATTERN_EN
        case (bar)
          13'd0:   rgb_d = 24'hFFFFFF;
          13'd1:   rgb_d = 24'hFFFF00;
          13'd2:   rgb_d = 24'h00FFFF;
          13'd3:   rgb_d = 24'h00FF00;
          13'd4:   rgb_d = 24'hFF00FF;
          13'd5:   rgb_d = 24'hFF0000;
          13'd6:   rgb_d = 24'h0000FF;
          default: rgb_d = 24'h000000;
        endcase
`else
        rgb_d = 24'h000000;
`endif
      end
    end
    // A new underflow outranks the frame-start clear.
    underflow_d = (active && empty) || (underflow_q && !frame_start_d);
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hc_q          <= 13'd0;
      vc_q          <= 13'd0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 24'h000000;
      end
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      x_q           <= 13'd0;
      y_q           <= 13'd0;
      de_q          <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      rgb_q         <= 24'h000000;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule
`default_nettype wire
